tick_timer: RTL and testbench

TICK_TIMER -- requirements
Module: tick_timer

---
 rtl/tick_timer_if.sv | 27 ++
 rtl/tick_timer.sv | 104 ++++++++++
 tb/tb_tick_timer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/tick_timer_if.sv
// Tick timer control/status bundle: master drives control strobes and the
// load value; slave (the timer) returns status and count.
interface tick_timer_if #(
  parameter int W = 16
) ();
  logic         tick_in;
  logic         start;
  logic         stop;
  logic         mode;
  logic [W-1:0] load_val;
  logic         irq_clr;
  logic         busy;
  logic [W-1:0] cnt;
  logic         done;
  logic         irq;
  logic         irq_ovr;

  modport master (
    output tick_in, start, stop, mode, load_val, irq_clr,
    input  busy, cnt, done, irq, irq_ovr
  );

  modport slave (
    input  tick_in, start, stop, mode, load_val, irq_clr,
    output busy, cnt, done, irq, irq_ovr
  );
endinterface

// File: rtl/tick_timer.sv
// Tick-driven down-counter timer with one-shot / periodic modes, a one-cycle
// done pulse and sticky irq / irq_ovr flags. All outputs come from registers.
module tick_timer #(
  parameter int W = 16
) (
  input  logic      clk,
  input  logic      rst,
  tick_timer_if.slave bus
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [W-1:0] ONE = W'(1);

  state_t       state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] reload_q, reload_d;
  logic         mode_q, mode_d;
  logic         done_q, done_d;
  logic         irq_q, irq_d;
  logic         ovr_q, ovr_d;
  logic         expire;

  // State and output registers; reset clears everything regardless of inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reload_q <= '0;
      mode_q   <= 1'b0;
      done_q   <= 1'b0;
      irq_q    <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      irq_q    <= irq_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next-state, count and flag logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    reload_d = reload_q;
    mode_d   = mode_q;
    done_d   = 1'b0;
    irq_d    = irq_q;
    ovr_d    = ovr_q;
    expire   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && (bus.load_val != '0)) begin
          cnt_d    = bus.load_val;
          reload_d = bus.load_val;
          mode_d   = bus.mode;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (bus.tick_in) begin
          if (cnt_q > ONE) begin
            cnt_d = cnt_q - ONE;
          end else if (cnt_q == ONE) begin
            expire = 1'b1;
            done_d = 1'b1;
            if (mode_q) begin
              cnt_d = reload_q;
            end else begin
              cnt_d   = '0;
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // An expiry beats a same-cycle irq_clr; in that case irq_ovr is left as is.
    if (expire) begin
      irq_d = 1'b1;
      if (!bus.irq_clr && irq_q) begin
        ovr_d = 1'b1;
      end
    end else if (bus.irq_clr) begin
      irq_d = 1'b0;
      ovr_d = 1'b0;
    end
  end

  assign bus.busy    = (state_q == RUN);
  assign bus.cnt     = cnt_q;
  assign bus.done    = done_q;
  assign bus.irq     = irq_q;
  assign bus.irq_ovr = ovr_q;

endmodule

// File: tb/tb_tick_timer.sv
// Bench for tick_timer: directed scenarios followed by random stimulus, all
// checked against a tick-counting reference model.
module tb_tick_timer;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tick_timer_if #(.W(W)) bus ();

  tick_timer #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference model: counts ticks since arming; count is period minus
  // ticks modulo period, expiry whenever ticks reaches a multiple of period.
  bit          m_run;
  bit          m_periodic;
  int unsigned m_period;
  int unsigned m_ticks;
  logic [31:0] m_held;
  bit          m_irq, m_ovr, m_done;

  function automatic logic [31:0] m_cnt();
    return m_run ? 32'(m_period - (m_ticks % m_period)) : m_held;
  endfunction

  task automatic model_update(input bit r, t, s, p, md, input int unsigned lv, input bit c);
    m_done = 1'b0;
    if (r) begin
      m_run = 0; m_periodic = 0; m_period = 0; m_ticks = 0;
      m_held = 0; m_irq = 0; m_ovr = 0;
      return;
    end
    if (!m_run) begin
      if (s && !p && lv != 0) begin
        m_run = 1; m_period = lv; m_periodic = md; m_ticks = 0;
      end
    end else if (p) begin
      m_held = m_cnt();
      m_run  = 0;
    end else if (t) begin
      m_ticks++;
      if (m_ticks % m_period == 0) begin
        m_done = 1'b1;
        if (!m_periodic) begin
          m_run  = 0;
          m_held = 0;
        end
      end
    end
    if (m_done) begin
      if (!c && m_irq) m_ovr = 1;
      m_irq = 1;
    end else if (c) begin
      m_irq = 0;
      m_ovr = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, update model at posedge, sample #1 later.
  task automatic step(input bit r, t, s, p, md, input int unsigned lv, input bit c);
    rst          = r;
    bus.tick_in  = t;
    bus.start    = s;
    bus.stop     = p;
    bus.mode     = md;
    bus.load_val = W'(lv);
    bus.irq_clr  = c;
    @(posedge clk);
    model_update(r, t, s, p, md, lv, c);
    #1;
    chk("busy",    32'(bus.busy),    32'(m_run));
    chk("cnt",     32'(bus.cnt),     m_cnt());
    chk("done",    32'(bus.done),    32'(m_done));
    chk("irq",     32'(bus.irq),     32'(m_irq));
    chk("irq_ovr", 32'(bus.irq_ovr), 32'(m_ovr));
    @(negedge clk);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    step(0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.tick_in = 0; bus.start = 0; bus.stop = 0; bus.mode = 0;
    bus.load_val = '0; bus.irq_clr = 0;
    @(negedge clk);

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 9, 1);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_cnt",  32'(bus.cnt),  0);

    // One-shot, load 3, ticks from an 8-bit counter overflow (every 256 cycles)
    step(0, 0, 1, 0, 0, 3, 0);
    chk("os_load", 32'(bus.cnt), 3);
    for (int k = 1; k <= 3; k++) begin
      idle(255);
      tick();
    end
    chk("os_cnt",  32'(bus.cnt),  0);
    chk("os_done", 32'(bus.done), 1);
    chk("os_irq",  32'(bus.irq),  1);
    chk("os_busy", 32'(bus.busy), 0);
    idle(1);
    chk("os_done_pulse", 32'(bus.done), 0);

    // Periodic, load 2, six ticks, no irq_clr after the first clear
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 2, 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k % 2 == 0) begin
        chk("per_done", 32'(bus.done), 1);
        chk("per_cnt",  32'(bus.cnt),  2);
      end
      if (k == 4) chk("per_ovr", 32'(bus.irq_ovr), 1);
      idle(1);
    end
    chk("per_busy", 32'(bus.busy), 1);
    step(0, 0, 0, 1, 0, 0, 0);

    // Back-to-back ticks, periodic load 1
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b2b_done", 32'(bus.done), 1);
      chk("b2b_cnt",  32'(bus.cnt),  1);
    end
    step(0, 0, 0, 1, 0, 0, 0);

    // Collision: stop and tick at cnt=1
    step(0, 0, 1, 0, 0, 2, 0);
    tick();
    step(0, 1, 0, 1, 0, 0, 0);
    chk("col_done", 32'(bus.done), 0);
    chk("col_cnt",  32'(bus.cnt),  1);
    chk("col_busy", 32'(bus.busy), 0);

    // Collision: irq_clr with same-cycle expiry
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 1, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0, 1);
    chk("clr_irq",  32'(bus.irq),  1);
    chk("clr_done", 32'(bus.done), 1);

    // Ignored starts
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0);
    chk("zero_busy", 32'(bus.busy), 0);
    chk("zero_cnt",  32'(bus.cnt),  0);
    step(0, 0, 1, 0, 0, 3, 0);
    tick();
    step(0, 0, 1, 0, 1, 7, 0);
    chk("restart_cnt", 32'(bus.cnt), 2);
    tick();
    tick();
    chk("restart_done", 32'(bus.done), 1);

    // Reset mid-run then a fresh start of 4
    step(0, 0, 1, 0, 0, 5, 0);
    tick();
    tick();
    step(1, 0, 0, 0, 0, 0, 0);
    chk("mrst_cnt",  32'(bus.cnt),  0);
    chk("mrst_busy", 32'(bus.busy), 0);
    chk("mrst_done", 32'(bus.done), 0);
    step(0, 0, 1, 0, 0, 4, 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("mrst_lat", 32'(bus.done), (k == 4) ? 1 : 0);
    end

    // Random stimulus
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 60) == 0,
           ($urandom % 3) == 0,
           ($urandom % 6) == 0,
           ($urandom % 25) == 0,
           1'($urandom % 2),
           $urandom_range(0, 4),
           ($urandom % 8) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
